ctrl_contador_corriente: RTL

//  Front-end controller for the 5-bit current-setpoint up/down counter.
//  - Arbitrates step requests from two requesters: manual push-buttons and an automatic source.
//  - Issues single-cycle enc/upc/downc strobes to the counter, with hold-to-repeat on buttons.
//  - Saturates at 0 and MAX_VAL using the counter value fed back, so the counter never wraps.

---
 rtl/ctrl_contador_corriente_pkg.sv | 25 ++
 rtl/ctrl_contador_corriente_if.sv | 27 ++
 rtl/ctrl_contador_corriente_temporizador_repeticion.sv | 31 +++
 rtl/ctrl_contador_corriente.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ctrl_contador_corriente_pkg.sv
// rtl/ctrl_contador_corriente_pkg.sv - shared widths, limits, state codes and strobe helper
package ctrl_contador_corriente_pkg;

    localparam int W = 5;
    localparam logic [W-1:0] MAX_VAL = W'(20);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STEP   = 3'd1,
        ST_GAP    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_REPEAT = 3'd4
    } state_t;

    localparam logic SRC_MAN  = 1'b0;
    localparam logic SRC_AUTO = 1'b1;

    // {enc, upc, downc} for one step, with saturation applied
    function automatic logic [2:0] strobe_for(input logic up, input logic [W-1:0] qc);
        logic ok;
        ok = up ? (qc < MAX_VAL) : (qc != '0);
        return {ok, ok & up, ok & ~up};
    endfunction

endpackage

// File: rtl/ctrl_contador_corriente_if.sv
// rtl/ctrl_contador_corriente_if.sv - request, feedback and strobe bundle
interface ctrl_contador_corriente_if;
    import ctrl_contador_corriente_pkg::*;

    logic         btn_up;
    logic         btn_down;
    logic         auto_req;
    logic         auto_dir;
    logic [W-1:0] qc_in;
    logic         enc;
    logic         upc;
    logic         downc;
    logic         busy;
    logic         sat_hi;
    logic         sat_lo;

    modport master (
        output btn_up, btn_down, auto_req, auto_dir, qc_in,
        input  enc, upc, downc, busy, sat_hi, sat_lo
    );

    modport slave (
        input  btn_up, btn_down, auto_req, auto_dir, qc_in,
        output enc, upc, downc, busy, sat_hi, sat_lo
    );

endinterface

// File: rtl/ctrl_contador_corriente_temporizador_repeticion.sv
// rtl/ctrl_contador_corriente_temporizador_repeticion.sv - loadable down-counter with done pulse
module temporizador_repeticion #(
    parameter int CW = 32
) (
    input  logic          clkc,
    input  logic          resetc,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          run,
    output logic          done
);

    logic [CW-1:0] cnt;

    // done is registered, so a load of N-1 makes done visible N cycles after the load
    always_ff @(posedge clkc) begin
        if (resetc) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (load) begin
            cnt  <= load_val;
            done <= 1'b0;
        end else if (run && cnt != '0) begin
            cnt  <= cnt - 1'b1;
            done <= (cnt == CW'(1));
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_contador_corriente.sv
// rtl/ctrl_contador_corriente.sv - arbitrates manual/auto steps into saturating counter strobes
module ctrl_contador_corriente
    import ctrl_contador_corriente_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int REP_CYCLES  = 10_000_000
) (
    input  logic                     clkc,
    input  logic                     resetc,
    ctrl_contador_corriente_if.slave bus
);

    localparam int TW = $clog2((HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES) + 1;

    state_t        state;
    logic          src;
    logic          dir;
    logic          rep;
    logic          pend;
    logic          pend_dir;
    logic          btn_up_q;
    logic          btn_dn_q;
    logic          rise_up;
    logic          rise_dn;
    logic          man_req;
    logic          auto_av;
    logic          auto_up;
    logic          held;
    logic          tmr_load;
    logic          tmr_run;
    logic          tmr_done;
    logic [TW-1:0] tmr_val;

    assign rise_up  = bus.btn_up & ~btn_up_q;
    assign rise_dn  = bus.btn_down & ~btn_dn_q;
    assign man_req  = (rise_up | rise_dn) & ~(bus.btn_up & bus.btn_down);
    assign auto_av  = pend | bus.auto_req;
    assign auto_up  = pend ? pend_dir : bus.auto_dir;
    assign held     = dir ? (bus.btn_up & ~bus.btn_down) : (bus.btn_down & ~bus.btn_up);

    assign tmr_load = (state == ST_GAP);
    assign tmr_run  = (state == ST_HOLD) || (state == ST_REPEAT);
    assign tmr_val  = rep ? TW'(REP_CYCLES - 1) : TW'(HOLD_CYCLES - 1);

    temporizador_repeticion #(.CW(TW)) u_tmr (
        .clkc     (clkc),
        .resetc   (resetc),
        .load     (tmr_load),
        .load_val (tmr_val),
        .run      (tmr_run),
        .done     (tmr_done)
    );

    always_ff @(posedge clkc) begin
        if (resetc) begin
            state      <= ST_IDLE;
            src        <= SRC_MAN;
            dir        <= 1'b0;
            rep        <= 1'b0;
            pend       <= 1'b0;
            pend_dir   <= 1'b0;
            btn_up_q   <= 1'b0;
            btn_dn_q   <= 1'b0;
            bus.enc    <= 1'b0;
            bus.upc    <= 1'b0;
            bus.downc  <= 1'b0;
            bus.busy   <= 1'b1 & 1'b0;
            bus.sat_hi <= 1'b0;
            bus.sat_lo <= 1'b0;
        end else begin
            btn_up_q   <= bus.btn_up;
            btn_dn_q   <= bus.btn_down;
            bus.sat_hi <= (bus.qc_in >= MAX_VAL);
            bus.sat_lo <= (bus.qc_in == '0);
            {bus.enc, bus.upc, bus.downc} <= 3'b000;
            bus.busy   <= 1'b1;

            // a request arriving while one is already pending is dropped, direction included
            if (bus.auto_req && !pend) begin
                pend     <= 1'b1;
                pend_dir <= bus.auto_dir;
            end

            case (state)
                ST_IDLE: begin
                    if (man_req) begin
                        state <= ST_STEP;
                        src   <= SRC_MAN;
                        dir   <= rise_up;
                        rep   <= 1'b0;
                        {bus.enc, bus.upc, bus.downc} <= strobe_for(rise_up, bus.qc_in);
                    end else if (auto_av) begin
                        state <= ST_STEP;
                        src   <= SRC_AUTO;
                        dir   <= auto_up;
                        rep   <= 1'b0;
                        pend  <= 1'b0;
                        {bus.enc, bus.upc, bus.downc} <= strobe_for(auto_up, bus.qc_in);
                    end else begin
                        bus.busy <= 1'b0;
                    end
                end
                ST_STEP: state <= ST_GAP;
                ST_GAP: begin
                    if (src == SRC_MAN && held) begin
                        state <= rep ? ST_REPEAT : ST_HOLD;
                    end else begin
                        state    <= ST_IDLE;
                        bus.busy <= pend | bus.auto_req;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!held) begin
                        state    <= ST_IDLE;
                        bus.busy <= pend | bus.auto_req;
                    end else if (tmr_done) begin
                        // the first repeat step fires as soon as the hold time expires
                        state <= ST_STEP;
                        rep   <= 1'b1;
                        {bus.enc, bus.upc, bus.downc} <= strobe_for(dir, bus.qc_in);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
